vedic_mult16_seq_ctrl: RTL and testbench
========================================

Name: vedic_mult16_seq_ctrl

Overview:
- Sequencing controller that computes a 16x16 unsigned product by time-multiplexing one 8x8 vedic multiplier over four partial-product cycles, accumulating into a 32-bit register.
- Optional approximate mode skips the low×low partial product (3 cycles) for the approximate-computing experiments.
- Sits between an operand source and a result sink, using valid/ready handshakes on both sides.
- Single in-flight operation; no input queueing.

Parameters:
- ALLOW_APPROX, 1: when 0, in_approx is ignored and every operation runs exact.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands (high only in IDLE)
- in_a  input  16  unsigned multiplicand
- in_b  input  16  unsigned multiplier
- in_approx  input  1  request approximate mode for this operation
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_p  output  32  product (exact, or approximate if out_approx)
- out_approx  output  1  result was produced in approximate mode
- busy  output  1  high in MUL or DONE

Behaviour:
- Reset is synchronous on rst_n==0 at a clock edge, and overrides everything, including a mid-operation MUL or DONE:
  - state=IDLE, step=0, acc=0
  - out_valid=0, out_p=0, out_approx=0, busy=0
  - in_ready=1 from the first edge with rst_n low onward
  - any in-flight operation is discarded; no result is emitted.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge:
    - latch in_a, in_b and the effective mode (in_approx && ALLOW_APPROX)
    - clear acc
    - set step=0 if exact, 1 if approximate
    - go to MUL.
  - Operand or in_approx changes after acceptance are ignored.
- MUL:
  - The multiplier is driven combinationally from the latched operand bytes selected by step. Each edge adds the shifted product to acc and increments step:
    - step0: AL×BL, shift 0
    - step1: AL×BH, shift 8
    - step2: AH×BL, shift 8
    - step3: AH×BH, shift 16
  - After the step3 edge, go to DONE. out_p<=final sum and out_valid<=1 are registered on that same edge.
  - in_ready=0 throughout; in_valid is ignored.
- DONE:
  - out_valid=1. out_p and out_approx are held stable until out_valid&&out_ready at an edge.
  - On that handshake: out_valid<=0 and go to IDLE. out_p keeps its last value.
  - New operands are not accepted in DONE; there is no same-cycle accept/complete.
- Latency:
  - Exact: out_valid rises 4 edges after the accept edge.
  - Approximate: out_valid rises 3 edges after the accept edge.
  - Minimum issue interval is accept + steps + 1 handshake cycle + 1 IDLE cycle, i.e. 6 cycles exact and 5 approximate, with out_ready tied high.
- Arithmetic:
  - Unsigned only. acc is 32 bits; the maximum sum 0xFFFE0001 cannot overflow, so no carry-out is kept.
  - Approximate result = exact − AL×BL, which is always less than 2^16 error.
- out_ready is don't-care outside DONE. out_valid never rises without a completed MUL sequence.

Decomposition:
- Shared package (mult_ctrl_pkg):
  - state encoding constants ST_IDLE, ST_MUL, ST_DONE
  - step index constants
  - operand width 16 and product width 32
- Sub-module: one instance of eight_bit_vedic_multiplier as the shared datapath.
- FSM, operand/byte muxing and accumulator stay in this module.

Test Plan:
- Exact basic: a=0x1234, b=0x5678, approx=0, out_ready=1 -> out_valid 4 edges after accept, out_p=0x06260060, out_approx=0; in_ready low from accept until return to IDLE.
- Corner values: 0xFFFF×0xFFFF -> 0xFFFE0001; 0x0000×0xABCD -> 0x00000000; 0x0001×0xFFFF -> 0x0000FFFF; 0x00FF×0xFF00 -> 0x00FE0100.
- Approximate: a=0x1234, b=0x5678, approx=1 -> out_valid 3 edges after accept, out_p=0x0625E800, out_approx=1. Repeat with ALLOW_APPROX=0 -> 0x06260060 after 4 edges, out_approx=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_p stable, in_ready=0, new in_valid ignored. Raise out_ready -> one handshake, then IDLE with in_ready=1; the next operand pair completes correctly.
- Operand stability: change in_a, in_b and in_approx every cycle after acceptance -> result reflects only the accepted values.
- Reset mid-operation: assert rst_n=0 for one edge during step2 -> state IDLE, out_valid=0, out_p=0, in_ready=1; the following 0x0003×0x0005 yields 0x0000000F with no stale result emitted.

Source files
------------

// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the sequential 16x16 vedic multiplier controller.
//   - state_t      : controller FSM encoding (IDLE / MUL / DONE)
//   - STEP_*       : partial-product step indices (which byte pair is multiplied)
//   - OP_W/PROD_W  : operand and product widths
//   - align_pp()   : places an 8x8 partial product at its weight for a given step
package mult_ctrl_pkg;

  localparam int OP_W   = 16;
  localparam int PROD_W = 32;
  localparam int BYTE_W = 8;
  localparam int PP_W   = 2 * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Step order: low x low, low x high, high x low, high x high.
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  // Cross terms carry weight 2^8, the high x high term weight 2^16.
  function automatic logic [PROD_W-1:0] align_pp(input logic [PP_W-1:0] pp,
                                                 input logic [1:0]      step);
    logic [PROD_W-1:0] w_res;
    w_res = '0;
    case (step)
      STEP_LL: w_res = {16'h0000, pp};
      STEP_LH,
      STEP_HL: w_res = {8'h00, pp, 8'h00};
      default: w_res = {pp, 16'h0000};
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/eight_bit_vedic_multiplier.sv
// Purely combinational 8x8 unsigned multiplier built in the vedic
// (urdhva-tiryagbhyam, "vertically and crosswise") style: a 2x2 cell, four
// of those form a 4x4, four 4x4 blocks form the 8x8.
// Ports (eight_bit_vedic_multiplier):
//   i_a [7:0]  multiplicand byte
//   i_b [7:0]  multiplier byte
//   o_p [15:0] product
module vedic_2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);
  logic w_t1;
  logic w_t2;
  logic w_hh;
  logic w_c;

  assign w_t1   = i_a[1] & i_b[0];
  assign w_t2   = i_a[0] & i_b[1];
  assign w_hh   = i_a[1] & i_b[1];
  assign w_c    = w_t1 & w_t2;
  assign o_p[0] = i_a[0] & i_b[0];
  assign o_p[1] = w_t1 ^ w_t2;
  assign o_p[2] = w_hh ^ w_c;
  assign o_p[3] = w_hh & w_c;
endmodule

module vedic_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  logic [3:0] w_q0;
  logic [3:0] w_q1;
  logic [3:0] w_q2;
  logic [3:0] w_q3;

  vedic_2x2 u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_p(w_q0));
  vedic_2x2 u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_p(w_q1));
  vedic_2x2 u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_p(w_q2));
  vedic_2x2 u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_p(w_q3));

  // Crosswise terms land at weight 2^2, the vertical high term at 2^4.
  assign o_p = {4'h0, w_q0} + {2'b00, w_q1, 2'b00} + {2'b00, w_q2, 2'b00} + {w_q3, 4'h0};
endmodule

module eight_bit_vedic_multiplier (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);
  logic [7:0] w_q0;
  logic [7:0] w_q1;
  logic [7:0] w_q2;
  logic [7:0] w_q3;

  vedic_4x4 u_ll (.i_a(i_a[3:0]), .i_b(i_b[3:0]), .o_p(w_q0));
  vedic_4x4 u_hl (.i_a(i_a[7:4]), .i_b(i_b[3:0]), .o_p(w_q1));
  vedic_4x4 u_lh (.i_a(i_a[3:0]), .i_b(i_b[7:4]), .o_p(w_q2));
  vedic_4x4 u_hh (.i_a(i_a[7:4]), .i_b(i_b[7:4]), .o_p(w_q3));

  assign o_p = {8'h00, w_q0} + {4'h0, w_q1, 4'h0} + {4'h0, w_q2, 4'h0} + {w_q3, 8'h00};
endmodule

// File: rtl/vedic_mult16_seq_ctrl.sv
// Sequential 16x16 unsigned multiplier: one shared 8x8 vedic multiplier is
// time-multiplexed over four partial products accumulated into a 32-bit sum.
// Approximate mode starts at step 1, skipping the low x low product.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   in_valid/in_ready  operand handshake (in_a, in_b, in_approx)
//   out_valid/out_ready result handshake (out_p, out_approx)
//   busy               high while in MUL or DONE
//   dbg_state          current FSM state (mult_ctrl_pkg::state_t encoding)
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. The producer holds valid and its data stable
// until that edge. Operands are only accepted in IDLE; the result is held in
// DONE until the sink takes it, and there is no same-cycle accept/complete.
module vedic_mult16_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter bit ALLOW_APPROX = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_approx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        out_approx,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  state_t            r_state;
  logic [1:0]        r_step;
  logic [PROD_W-1:0] r_acc;
  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  logic              r_approx;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_out_valid;
  logic [PROD_W-1:0] r_out_p;
  logic              r_out_approx;

  logic [BYTE_W-1:0] w_mul_a;
  logic [BYTE_W-1:0] w_mul_b;
  logic [PP_W-1:0]   w_pp;
  logic [PROD_W-1:0] w_acc_next;
  logic              w_eff_approx;

  // Byte selection for the shared multiplier, driven by the current step.
  always_comb begin
    w_mul_a = r_a[7:0];
    w_mul_b = r_b[7:0];
    case (r_step)
      STEP_LH: w_mul_b = r_b[15:8];
      STEP_HL: w_mul_a = r_a[15:8];
      STEP_HH: begin
        w_mul_a = r_a[15:8];
        w_mul_b = r_b[15:8];
      end
      default: ;
    endcase
  end

  eight_bit_vedic_multiplier u_mul (
    .i_a(w_mul_a),
    .i_b(w_mul_b),
    .o_p(w_pp)
  );

  // Largest possible sum is 0xFFFE0001, so a 32-bit accumulator never carries out.
  assign w_acc_next   = r_acc + align_pp(w_pp, r_step);
  assign w_eff_approx = in_approx & ALLOW_APPROX;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_step       <= STEP_LL;
      r_acc        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_approx     <= 1'b0;
      r_in_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_p      <= '0;
      r_out_approx <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_approx   <= w_eff_approx;
            r_acc      <= '0;
            r_step     <= w_eff_approx ? STEP_LH : STEP_LL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc  <= w_acc_next;
          r_step <= r_step + 2'd1;
          if (r_step == STEP_HH) begin
            // Result is registered on the same edge as the last accumulation.
            r_out_p      <= w_acc_next;
            r_out_approx <= r_approx;
            r_out_valid  <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign out_valid  = r_out_valid;
  assign out_p      = r_out_p;
  assign out_approx = r_out_approx;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_vedic_mult16_seq_ctrl.sv
module tb_vedic_mult16_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_approx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        out_approx;
  logic        busy;
  logic [1:0]  dbg_state;

  // Second instance with approximation disabled, sharing operands/out_ready.
  logic        in_valid2;
  logic        in_ready2;
  logic        out_valid2;
  logic [31:0] out_p2;
  logic        out_approx2;
  logic        busy2;
  logic [1:0]  dbg_state2;

  vedic_mult16_seq_ctrl #(.ALLOW_APPROX(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_approx(out_approx),
    .busy(busy), .dbg_state(dbg_state)
  );

  vedic_mult16_seq_ctrl #(.ALLOW_APPROX(1'b0)) dut_exact (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid2),
    .out_ready(out_ready), .out_p(out_p2), .out_approx(out_approx2),
    .busy(busy2), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];   // {approx, product}
  int checks   = 0;
  int failures = 0;

  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ap);
    logic [31:0] p;
    logic [31:0] ll;
    p  = {16'h0000, a} * {16'h0000, b};
    ll = {24'h000000, a[7:0]} * {24'h000000, b[7:0]};
    if (ap) p = p - ll;
    return {ap, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic ap);
    in_a      = a;
    in_b      = b;
    in_approx = ap;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Waits (bounded) for out_valid; k counts edges after the accept edge.
  task automatic wait_result(input string tag, input int lat, input bit scramble);
    int k;
    bit rdy_low;
    logic [32:0] e;
    k = 0;
    rdy_low = 1'b1;
    while (out_valid !== 1'b1 && k < 20) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) rdy_low = 1'b0;
      @(negedge clk);
      if (scramble) begin
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        in_approx = 1'($urandom_range(0, 1));
      end
      k++;
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_in_ready_low"}, {31'd0, rdy_low}, 32'd1);
    if (exp_q.size() == 0) e = '0;
    else e = exp_q.pop_front();
    check({tag, "_out_p"}, out_p, e[31:0]);
    check({tag, "_out_approx"}, {31'd0, out_approx}, {31'd0, e[32]});
    check({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Assumes out_ready is high; one edge completes the handshake.
  task automatic handshake(input string tag);
    @(negedge clk);
    check({tag, "_hs_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hs_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_hs_busy"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t corners[4];

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    bit flag;
    logic [31:0] p_hold;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rap;

    corners[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    corners[1] = '{16'h0000, 16'hABCD, 32'h00000000};
    corners[2] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    corners[3] = '{16'h00FF, 16'hFF00, 32'h00FE0100};

    rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_approx = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_p", out_p, 32'd0);
    check("rst_out_approx", {31'd0, out_approx}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact basic
    exp_q.push_back({1'b0, 32'h06260060});
    issue(16'h1234, 16'h5678, 1'b0);
    wait_result("exact_basic", 4, 1'b0);
    handshake("exact_basic");

    // Corners, back to back at the minimum issue interval
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, corners[i].p});
      issue(corners[i].a, corners[i].b, 1'b0);
      wait_result($sformatf("corner%0d", i), 4, 1'b0);
      handshake($sformatf("corner%0d", i));
    end

    // Approximate
    exp_q.push_back({1'b1, 32'h0625E800});
    issue(16'h1234, 16'h5678, 1'b1);
    wait_result("approx_basic", 3, 1'b0);
    handshake("approx_basic");

    // Approx request with approximation disabled
    in_a = 16'h1234; in_b = 16'h5678; in_approx = 1'b1; in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    k = 0;
    while (out_valid2 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("noapprox_latency", k, 4);
    check("noapprox_out_p", out_p2, 32'h06260060);
    check("noapprox_out_approx", {31'd0, out_approx2}, 32'd0);
    @(negedge clk);
    check("noapprox_hs_out_valid", {31'd0, out_valid2}, 32'd0);
    check("noapprox_hs_in_ready", {31'd0, in_ready2}, 32'd1);

    // Backpressure
    out_ready = 1'b0;
    exp_q.push_back(model(16'hA5A5, 16'h5A5A, 1'b0));
    issue(16'hA5A5, 16'h5A5A, 1'b0);
    wait_result("bp", 4, 1'b0);
    p_hold = out_p;
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      @(negedge clk);
      if (out_p !== p_hold || in_ready !== 1'b0 || out_valid !== 1'b1 || dbg_state !== 2'd2)
        flag = 1'b0;
    end
    check("bp_hold_stable", {31'd0, flag}, 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    handshake("bp");
    check("bp_out_p_kept", out_p, p_hold);
    exp_q.push_back(model(16'h0F0F, 16'h1357, 1'b0));
    issue(16'h0F0F, 16'h1357, 1'b0);
    wait_result("bp_next", 4, 1'b0);
    handshake("bp_next");

    // Operand stability: inputs scrambled every cycle after accept
    exp_q.push_back(model(16'hBEEF, 16'hCAFE, 1'b0));
    issue(16'hBEEF, 16'hCAFE, 1'b0);
    wait_result("stable_exact", 4, 1'b1);
    handshake("stable_exact");
    exp_q.push_back(model(16'hBEEF, 16'hCAFE, 1'b1));
    issue(16'hBEEF, 16'hCAFE, 1'b1);
    wait_result("stable_approx", 3, 1'b1);
    handshake("stable_approx");

    // Random operands in both modes
    for (int i = 0; i < 8; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rap = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rb, rap));
      issue(ra, rb, rap);
      wait_result($sformatf("rand%0d", i), rap ? 3 : 4, 1'b0);
      handshake($sformatf("rand%0d", i));
    end

    // Reset during step 2
    issue(16'h7777, 16'h9999, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_p", out_p, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    flag = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) flag = 1'b0;
    end
    check("midrst_no_stale", {31'd0, flag}, 32'd1);
    exp_q.push_back({1'b0, 32'h0000000F});
    issue(16'h0003, 16'h0005, 1'b0);
    wait_result("after_rst", 4, 1'b0);
    handshake("after_rst");

    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
